// File: rtl/tmp_uart_formatter_if.sv
`default_nettype none
// ============================================================================
// Module   : tmp_uart_formatter_if
// Brief    : Request/character bundle between a host, the temperature
//            formatter and a UART transmit buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface tmp_uart_formatter_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [11:0]      temperature;
    logic             tx_full;
    logic [WIDTH-1:0] tx_data;
    logic             write_to_uart;
    logic             busy;
    logic             done;

    modport master (
        output start, temperature, tx_full,
        input  tx_data, write_to_uart, busy, done
    );

    modport slave (
        input  start, temperature, tx_full,
        output tx_data, write_to_uart, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/tmp_uart_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tmp_uart_formatter
// Brief    : Turns a TMP101 reading into "sSSS.F" + CR[LF] ASCII characters
//            for a UART transmit buffer. Define TMP_FMT_PREFIX_EN to prefix
//            every message with "T=".
// Revision : 1.0 - initial release
// ============================================================================
module tmp_uart_formatter #(
    parameter int TERMINATE_CRLF   = 1,
    parameter int TRANSMITTED_BITS = 8
) (
    input  wire logic           clock,
    input  wire logic           reset,
    tmp_uart_formatter_if.slave bus
);

`ifdef TMP_FMT_PREFIX_EN
    localparam int c_PREFIX_LEN = 2;
    localparam logic [7:0] c_CHAR_T  = 8'h54;
    localparam logic [7:0] c_CHAR_EQ = 8'h3D;
`else
    localparam int c_PREFIX_LEN = 0;
`endif
    localparam int c_BODY_LEN = (TERMINATE_CRLF != 0) ? 8 : 7;
    localparam int c_MSG_LEN  = c_PREFIX_LEN + c_BODY_LEN;
    localparam int c_IDX_W    = $clog2(c_MSG_LEN);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_MSG_LEN - 1);
    localparam logic [7:0] c_ASCII_0 = 8'h30;
    localparam logic [7:0] c_PLUS    = 8'h2B;
    localparam logic [7:0] c_MINUS   = 8'h2D;
    localparam logic [7:0] c_DOT     = 8'h2E;
    localparam logic [7:0] c_CR      = 8'h0D;
    localparam logic [7:0] c_LF      = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONVERT = 3'd1,
        S_SEND    = 3'd2,
        S_GAP     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [11:0]                 r_temp;
    logic [c_IDX_W-1:0]          r_idx;
    logic [c_IDX_W-1:0]          w_idx_next;
    logic [TRANSMITTED_BITS-1:0] r_tx_data;
    logic [TRANSMITTED_BITS-1:0] r_msg [c_MSG_LEN];
    logic [TRANSMITTED_BITS-1:0] w_msg [c_MSG_LEN];
    logic [7:0]                  w_body [8];
    logic [11:0]                 w_mag;
    logic [7:0]                  w_int;
    logic [7:0]                  w_frac10;
    logic                        w_last;
    logic                        w_write;
    logic                        w_busy;
    logic                        w_done;

    assign w_last     = (r_idx == c_LAST_IDX);
    assign w_idx_next = r_idx + c_IDX_W'(1);

    // 0x800 negates to itself, which as unsigned is exactly 2048 (128.0 C).
    always_comb begin
        w_mag    = r_temp[11] ? (12'd0 - r_temp) : r_temp;
        w_int    = w_mag[11:4];
        w_frac10 = {4'd0, w_mag[3:0]} * 8'd10;

        w_body[0] = r_temp[11] ? c_MINUS : c_PLUS;
        w_body[1] = c_ASCII_0 + (w_int / 8'd100);
        w_body[2] = c_ASCII_0 + ((w_int / 8'd10) % 8'd10);
        w_body[3] = c_ASCII_0 + (w_int % 8'd10);
        w_body[4] = c_DOT;
        w_body[5] = c_ASCII_0 + (w_frac10 >> 4);
        w_body[6] = c_CR;
        w_body[7] = c_LF;
    end

    always_comb begin
        for (int i = 0; i < c_MSG_LEN; i++) begin
            w_msg[i] = '0;
        end
`ifdef TMP_FMT_PREFIX_EN
        w_msg[0] = c_CHAR_T;
        w_msg[1] = c_CHAR_EQ;
`endif
        w_msg[c_PREFIX_LEN + 0] = w_body[0];
        w_msg[c_PREFIX_LEN + 1] = w_body[1];
        w_msg[c_PREFIX_LEN + 2] = w_body[2];
        w_msg[c_PREFIX_LEN + 3] = w_body[3];
        w_msg[c_PREFIX_LEN + 4] = w_body[4];
        w_msg[c_PREFIX_LEN + 5] = w_body[5];
        w_msg[c_PREFIX_LEN + 6] = w_body[6];
        if (TERMINATE_CRLF != 0) begin
            w_msg[c_MSG_LEN - 1] = w_body[7];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                w_busy       = 1'b1;
                w_state_next = S_SEND;
            end
            S_SEND: begin
                w_busy = 1'b1;
                if (!bus.tx_full) begin
                    w_write      = 1'b1;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                w_busy       = 1'b1;
                w_state_next = w_last ? S_DONE : S_SEND;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // tx_data is loaded on entry to SEND so it is already stable when the strobe rises.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_temp    <= '0;
            r_idx     <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_temp <= bus.temperature;
                    end
                end
                S_CONVERT: begin
                    r_idx     <= '0;
                    r_tx_data <= w_msg[0];
                end
                S_GAP: begin
                    if (!w_last) begin
                        r_idx     <= w_idx_next;
                        r_tx_data <= r_msg[w_idx_next];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (r_state == S_CONVERT) begin
            r_msg <= w_msg;
        end
    end

    // The strobe is gated by reset so an abort never writes in the reset cycle.
    assign bus.write_to_uart = w_write & ~reset;
    assign bus.tx_data       = r_tx_data;
    assign bus.busy          = w_busy;
    assign bus.done          = w_done;

endmodule
`default_nettype wire

// File: tb/tb_tmp_uart_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmp_uart_formatter
// Brief    : Scoreboard bench for tmp_uart_formatter (honours TMP_FMT_PREFIX_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmp_uart_formatter;

    localparam int c_CRLF = 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_done = 0;
    string prefix_str;
    exp_t  exp_q[$];
    exp_t  mon_e;

    logic [11:0] temps [7] = '{12'h190, 12'hE70, 12'h198, 12'h00F, 12'h7FF, 12'h800, 12'h000};
    string       strs  [7] = '{"+025.0", "-025.0", "+025.5", "+000.9", "+127.9", "-128.0", "+000.0"};

    tmp_uart_formatter_if bus_if ();

    tmp_uart_formatter #(
        .TERMINATE_CRLF   (c_CRLF),
        .TRANSMITTED_BITS (8)
    ) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        if (obs !== expd) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expd, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus_if.write_to_uart === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, bus_if.write_to_uart}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_data", {24'd0, bus_if.tx_data}, {24'd0, mon_e.data});
                check("write_cycle", cyc, mon_e.cyc);
            end
        end
        if (bus_if.done === 1'b1) n_done++;
    end

    task automatic send_reading(input logic [11:0] t, input string body, input int n_exp,
                                input int stall_char, input int stall_len,
                                output int n0, output int len);
        string msg;
        exp_t  e;
        int    shift;
        msg = {prefix_str, body};
        len = msg.len() + ((c_CRLF != 0) ? 2 : 1);
        @(negedge clk);
        n0 = cyc;
        for (int i = 0; i < len && i < n_exp; i++) begin
            if (i < msg.len())       e.data = msg[i];
            else if (i == msg.len()) e.data = 8'h0D;
            else                     e.data = 8'h0A;
            shift = (stall_char >= 0 && i >= stall_char) ? stall_len : 0;
            e.cyc = n0 + 2 + 2 * i + shift;
            exp_q.push_back(e);
        end
        bus_if.start       = 1'b1;
        bus_if.temperature = t;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("busy_after_start", {31'd0, bus_if.busy}, 32'd1);
    endtask

    task automatic wait_done(input int exp_cyc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("done_cycle", cyc, exp_cyc);
            check("busy_in_done", {31'd0, bus_if.busy}, 32'd0);
        end
        check("all_chars_written", exp_q.size(), 32'd0);
    endtask

    initial begin
        int n0;
        int len;
        int d0;
`ifdef TMP_FMT_PREFIX_EN
        prefix_str = "T=";
`else
        prefix_str = "";
`endif
        bus_if.start       = 1'b0;
        bus_if.temperature = 12'h000;
        bus_if.tx_full     = 1'b0;
        rst                = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_data", {24'd0, bus_if.tx_data}, 32'd0);
        check("rst_write", {31'd0, bus_if.write_to_uart}, 32'd0);
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst_done", {31'd0, bus_if.done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send_reading(temps[i], strs[i], 99, -1, 0, n0, len);
            wait_done(n0 + 2 * len + 2);
            repeat (2) @(negedge clk);
        end

        // Back-pressure on the third character for five cycles.
        send_reading(12'h190, "+025.0", 99, 2, 5, n0, len);
        while (cyc < n0 + 5) @(negedge clk);
        @(posedge clk);
        #1 bus_if.tx_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus_if.tx_full = 1'b0;
        wait_done(n0 + 2 * len + 2 + 5);
        repeat (2) @(negedge clk);

        // Start re-pulsed mid-message must be ignored.
        d0 = n_done;
        send_reading(12'h190, "+025.0", 99, -1, 0, n0, len);
        while (cyc < n0 + 5) @(negedge clk);
        bus_if.start       = 1'b1;
        bus_if.temperature = 12'h000;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done(n0 + 2 * len + 2);
        repeat (40) @(negedge clk);
        check("single_done_after_restart", n_done, d0 + 1);
        check("idle_after_restart", {31'd0, bus_if.busy}, 32'd0);

        // Reset in the middle of a message aborts it.
        d0 = n_done;
        send_reading(12'h190, "+025.0", 3, -1, 0, n0, len);
        while (cyc < n0 + 6) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("write_in_reset_cycle", {31'd0, bus_if.write_to_uart}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
        check("abort_tx_data", {24'd0, bus_if.tx_data}, 32'd0);
        check("abort_write", {31'd0, bus_if.write_to_uart}, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_no_done", n_done, d0);
        check("abort_chars_written", exp_q.size(), 32'd0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst                = 1'b1;
        bus_if.start       = 1'b1;
        bus_if.temperature = 12'h190;
        @(negedge clk);
        rst          = 1'b0;
        bus_if.start = 1'b0;
        @(negedge clk);
        check("reset_beats_start", {31'd0, bus_if.busy}, 32'd0);
        repeat (30) @(negedge clk);
        check("reset_beats_start_done", n_done, d0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
